// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and default constants for the PLL reset/lock supervisor.
package pll_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset to 0.
// Reusable for any asynchronous status input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;

  // Two back-to-back flops: the first may go metastable, the second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// Reset/lock supervisor for the PLL wrapper: pulses pll_rst, waits for a
// stable synchronized lock, releases sys_rst, and re-runs the sequence on
// lock timeout or lock loss.
// Build option: PLL_RST_CTRL_RETRY_EN enables bounded timeout retries; without
// it the first WAIT_LOCK timeout goes straight to FAIL and retry_cnt stays 0.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter  int RST_CYCLES    = DEF_RST_CYCLES,
  parameter  int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter  int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter  int MAX_RETRY     = DEF_MAX_RETRY,
  localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic               lost_lock,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES);
  localparam int TO_W = $clog2(LOCK_TIMEOUT);
  localparam int ST_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  // lock_s is already high on the STABLE entry edge; counting to STABLE_CYCLES
  // puts release STABLE_CYCLES+3 edges after pll_lock is first sampled.
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES);

  state_t             state;
  state_t             state_nxt;
  logic               lock_s;
  logic               cnt_clr;
  logic               lost_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [RC_W-1:0]    rst_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [ST_W-1:0]    st_cnt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, retry bookkeeping and lost_lock decision; restart overrides all.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    case (state)
      RESET: begin
        if (rst_cnt == RC_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (to_cnt == TO_LAST) begin
`ifdef PLL_RST_CTRL_RETRY_EN
          if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = RESET;
          end else begin
            state_nxt = FAIL;
          end
`else
          state_nxt = FAIL;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (st_cnt == ST_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET;
          lost_nxt  = 1'b1;
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = RESET;
      end
    endcase
    if (restart) begin
      state_nxt = RESET;
      retry_nxt = '0;
      lost_nxt  = 1'b0;
    end
    cnt_clr = (state_nxt != state) || restart;
  end

  // Per-state counters, cleared on every state entry and on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
      st_cnt  <= '0;
    end else if (cnt_clr) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
      st_cnt  <= '0;
    end else begin
      if (state == RESET)     rst_cnt <= rst_cnt + RC_W'(1);
      if (state == WAIT_LOCK) to_cnt  <= to_cnt + TO_W'(1);
      if (state == STABLE)    st_cnt  <= st_cnt + ST_W'(1);
    end
  end

  // State register and outputs decoded from the next state, so they change
  // on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lost_lock <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pll_rst   <= (state_nxt == RESET) || (state_nxt == FAIL);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
      lost_lock <= lost_nxt;
      retry_cnt <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl: directed vector table, hand-written
// corner sequences, and randomized lock/restart traffic against a reference model.
// Honours PLL_RST_CTRL_RETRY_EN the same way as the design.
module tb_pll_rst_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
`ifdef PLL_RST_CTRL_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lost_lock;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  pll_rst_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .lost_lock (lost_lock),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phases with an age in edges, lock seen two edges late.
  typedef enum {M_PLLRST, M_WAIT, M_STAB, M_RUN, M_DEAD} mphase_t;
  mphase_t m_ph;
  int      m_age;
  int      m_retries;
  bit      m_lost;
  bit      q_sync[$];

  function automatic void enter(input mphase_t p);
    m_ph  = p;
    m_age = 0;
  endfunction

  function automatic void model_reset();
    enter(M_PLLRST);
    m_retries = 0;
    m_lost    = 1'b0;
    q_sync.delete();
    q_sync.push_back(1'b0);
    q_sync.push_back(1'b0);
  endfunction

  function automatic void model_edge(input bit lock, input bit rs);
    bit ls;
    ls = q_sync.pop_front();
    q_sync.push_back(lock);
    m_lost = 1'b0;
    if (rs) begin
      enter(M_PLLRST);
      m_retries = 0;
      return;
    end
    m_age++;
    case (m_ph)
      M_PLLRST: if (m_age == RST_CYCLES) enter(M_WAIT);
      M_WAIT: begin
        if (ls) enter(M_STAB);
        else if (m_age == LOCK_TIMEOUT) begin
          if (RETRY_EN && m_retries < MAX_RETRY) begin
            m_retries++;
            enter(M_PLLRST);
          end else begin
            enter(M_DEAD);
          end
        end
      end
      M_STAB: begin
        // Entry edge already has lock_s high; release after STABLE_CYCLES+1
        // high edges in STABLE, i.e. STABLE_CYCLES+3 after the first sample.
        if (!ls) enter(M_WAIT);
        else if (m_age == STABLE_CYCLES + 1) begin
          enter(M_RUN);
          m_retries = 0;
        end
      end
      M_RUN: if (!ls) begin
        m_lost = 1'b1;
        enter(M_PLLRST);
      end
      default: ;
    endcase
  endfunction

  function automatic int model_outs();
    bit p, s, y, f;
    p = (m_ph == M_PLLRST) || (m_ph == M_DEAD);
    s = (m_ph != M_RUN);
    y = (m_ph == M_RUN);
    f = (m_ph == M_DEAD);
    return int'({p, s, y, f, m_lost, 2'(m_retries)});
  endfunction

  function automatic int dut_outs();
    return int'({pll_rst, sys_rst, ready, fail, lost_lock, retry_cnt});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(pll_lock, restart);
    #1;
    chk("model {pll_rst,sys_rst,ready,fail,lost_lock,retry_cnt}", dut_outs(), model_outs());
  endtask

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (!ready && n < limit) begin
      tick();
      n++;
    end
    chk("reach RUN", int'(ready), 1);
  endtask

  typedef struct {
    logic       lock;
    logic       rs;
    int         n;
    logic [4:0] exp;   // {pll_rst, sys_rst, ready, fail, lost_lock}
  } vec_t;

  vec_t vec[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int attempts, pulses, max_retry, lat, seg;
    bit prev_pll, done;

    // Nominal release, lock loss, restart and one-cycle lock chatter.
    vec[0]  = '{1'b0, 1'b0,  3, 5'b11000};
    vec[1]  = '{1'b0, 1'b0,  1, 5'b01000};
    vec[2]  = '{1'b0, 1'b0,  9, 5'b01000};
    vec[3]  = '{1'b1, 1'b0, 10, 5'b01000};
    vec[4]  = '{1'b1, 1'b0,  1, 5'b01000};
    vec[5]  = '{1'b1, 1'b0,  1, 5'b00100};
    vec[6]  = '{1'b1, 1'b0,  5, 5'b00100};
    vec[7]  = '{1'b0, 1'b0,  2, 5'b00100};
    vec[8]  = '{1'b0, 1'b0,  1, 5'b11001};
    vec[9]  = '{1'b1, 1'b0,  1, 5'b11000};
    vec[10] = '{1'b1, 1'b0,  2, 5'b11000};
    vec[11] = '{1'b1, 1'b0,  1, 5'b01000};
    vec[12] = '{1'b1, 1'b0,  9, 5'b01000};
    vec[13] = '{1'b1, 1'b0,  1, 5'b00100};
    vec[14] = '{1'b1, 1'b1,  1, 5'b11000};
    vec[15] = '{1'b1, 1'b0,  4, 5'b01000};
    vec[16] = '{1'b1, 1'b0,  3, 5'b01000};
    vec[17] = '{1'b0, 1'b0,  1, 5'b01000};
    vec[18] = '{1'b1, 1'b0, 11, 5'b01000};
    vec[19] = '{1'b1, 1'b0,  1, 5'b00100};

    rst      = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    model_reset();
    #2;
    chk("reset values", dut_outs(), int'(7'b1100000));
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      pll_lock = vec[i].lock;
      restart  = vec[i].rs;
      for (int k = 0; k < vec[i].n; k++) tick();
      chk($sformatf("vector %0d", i), dut_outs(), int'({vec[i].exp, 2'b00}));
    end

    // Lock held low: timeouts, retries, then FAIL with pll_rst stuck high.
    attempts = RETRY_EN ? MAX_RETRY + 1 : 1;
    pll_lock = 1'b0;
    restart  = 1'b1;
    tick();
    restart   = 1'b0;
    pulses    = 1;
    max_retry = 0;
    lat       = 0;
    done      = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      prev_pll = pll_rst;
      tick();
      lat++;
      if (!fail && !prev_pll && pll_rst) pulses++;
      if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
      if (fail) done = 1'b1;
    end
    chk("fail reached", int'(done), 1);
    chk("fail latency", lat, attempts * (RST_CYCLES + LOCK_TIMEOUT));
    chk("reset pulses before fail", pulses, attempts);
    chk("max retry_cnt", max_retry, RETRY_EN ? MAX_RETRY : 0);
    pll_lock = 1'b1;
    repeat (30) tick();
    chk("fail sticky", int'({pll_rst, sys_rst, ready, fail}), int'(4'b1101));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart clears fail", int'({pll_rst, sys_rst, fail, retry_cnt}), int'(5'b11000));

    // restart in the same cycle as lock-loss detection in RUN.
    wait_ready(100);
    pll_lock = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("simultaneous: no lost_lock", int'({pll_rst, ready, lost_lock, retry_cnt}), int'(5'b10000));
    tick();
    chk("simultaneous: still no lost_lock", int'(lost_lock), 0);

    // Asynchronous rst partway through STABLE.
    pll_lock = 1'b1;
    restart  = 1'b1;
    tick();
    restart = 1'b0;
    repeat (RST_CYCLES + 1 + 3) tick();
    chk("in STABLE before rst", int'({pll_rst, sys_rst, ready}), int'(3'b010));
    #3;
    rst = 1'b1;
    #1;
    chk("async rst mid-STABLE", dut_outs(), int'(7'b1100000));
    tick();
    tick();
    rst = 1'b0;

    // Randomized lock segments and sparse restart pulses.
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        seg = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(1, 40));
      end
      seg--;
      restart = ($urandom_range(0, 149) == 0);
      tick();
    end
    restart = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
